// File: rtl/a2d_sampler.sv
// Initiator for the A2D strt/chnl/cmplt handshake: paces conversions, averages blocks of
// 2**AVG_LOG2 samples alternately on CH0 (temp) and CH1 (press), and flags timeouts.
module a2d_sampler #(
  parameter int AVG_LOG2 = 2,
  parameter int IVL_W    = 16,
  parameter int TIMEOUT  = 31
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [IVL_W-1:0] interval,
  output logic             strt,
  output logic             chnl,
  input  logic             cmplt,
  input  logic [15:0]      a2d,
  output logic [15:0]      temp,
  output logic [15:0]      press,
  output logic             temp_vld,
  output logic             press_vld,
  output logic             tmo_err
);

  localparam int ACC_W = 16 + AVG_LOG2;
  localparam int WT_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

  state_t              state;
  logic [IVL_W-1:0]    idle_cnt;
  logic [WT_W-1:0]     wait_cnt;
  logic [AVG_LOG2-1:0] smp_cnt;
  logic [ACC_W-1:0]    acc;
  logic [ACC_W-1:0]    sum;
  logic                blk_last;

  // sum includes the sample being accepted, so the average is published the cycle after cmplt
  assign sum      = acc + ACC_W'(a2d);
  assign blk_last = &smp_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idle_cnt  <= '0;
      wait_cnt  <= '0;
      smp_cnt   <= '0;
      acc       <= '0;
      strt      <= 1'b0;
      chnl      <= 1'b0;
      temp      <= '0;
      press     <= '0;
      temp_vld  <= 1'b0;
      press_vld <= 1'b0;
      tmo_err   <= 1'b0;
    end else begin
      strt      <= 1'b0;
      temp_vld  <= 1'b0;
      press_vld <= 1'b0;
      tmo_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (!en) begin
            idle_cnt <= '0;
          end else if (idle_cnt >= interval) begin
            // counter is cleared on exit so it starts from zero on the next IDLE entry
            idle_cnt <= '0;
            strt     <= 1'b1;
            state    <= START;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        START: begin
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (cmplt) begin
            state <= IDLE;
            if (blk_last) begin
              if (chnl) begin
                press     <= sum[15+AVG_LOG2:AVG_LOG2];
                press_vld <= 1'b1;
              end else begin
                temp     <= sum[15+AVG_LOG2:AVG_LOG2];
                temp_vld <= 1'b1;
              end
              acc     <= '0;
              smp_cnt <= '0;
              chnl    <= ~chnl;
            end else begin
              acc     <= sum;
              smp_cnt <= smp_cnt + 1'b1;
            end
          end else if (wait_cnt == WT_W'(TIMEOUT)) begin
            // abandon the whole block; channel stays so the block restarts cleanly
            tmo_err <= 1'b1;
            acc     <= '0;
            smp_cnt <= '0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
